// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder controller: FSM state
// encoding and the default operand width.
package serial_adder_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int DEFAULT_WIDTH = 8;

endpackage

// File: rtl/full_adder.sv
// One-bit full adder: the only arithmetic element of the serial adder.
module full_adder (
    input  logic x,
    input  logic y,
    input  logic c_in,
    output logic s,
    output logic c_out
);

    // Sum and carry of a single bit pair plus incoming carry.
    always_comb begin
        s     = x ^ y ^ c_in;
        c_out = (x & y) | (c_in & (x ^ y));
    end

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder controller: accepts two operands plus carry-in, adds them
// LSB first through one full adder over WIDTH cycles, then holds the result
// until the consumer takes it.
// Optional: define SERIAL_ADDER_CTRL_OVF_EN to add the signed overflow output ovf.
//
//  state | meaning
//  IDLE  | waiting for operands, in_ready=1
//  SHIFT | adding one bit pair per cycle, WIDTH cycles
//  DONE  | result held, out_valid=1 until out_ready
module serial_adder_ctrl
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             c_out
`ifdef SERIAL_ADDER_CTRL_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int CW = $clog2(WIDTH) + 1;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] sum_sh;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic             last_bit;
    logic             fa_s;
    logic             fa_c;

    assign last_bit  = (cnt == CW'(WIDTH - 1));
    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    // The carry register holds the final carry once the last bit is added.
    assign sum       = sum_sh;
    assign c_out     = carry;

    full_adder u_fa (
        .x     (a_sh[0]),
        .y     (b_sh[0]),
        .c_in  (carry),
        .s     (fa_s),
        .c_out (fa_c)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; clear overrides every handshake.
    always_comb begin
        state_nxt = state;
        if (clear) begin
            state_nxt = IDLE;
        end else begin
            unique case (state)
                IDLE:    if (in_valid)  state_nxt = SHIFT;
                SHIFT:   if (last_bit)  state_nxt = DONE;
                DONE:    if (out_ready) state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Operand shifters, sum shifter, carry and bit counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_sh   <= '0;
            b_sh   <= '0;
            sum_sh <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
        end else if (clear) begin
            sum_sh <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_sh  <= a;
                        b_sh  <= b;
                        carry <= c_in;
                        cnt   <= '0;
                    end
                end
                SHIFT: begin
                    a_sh   <= a_sh >> 1;
                    b_sh   <= b_sh >> 1;
                    sum_sh <= {fa_s, sum_sh[WIDTH-1:1]};
                    carry  <= fa_c;
                    cnt    <= cnt + CW'(1);
                end
                default: ;
            endcase
        end
    end

`ifdef SERIAL_ADDER_CTRL_OVF_EN
    logic ovf_r;

    // On the MSB the carry register is the carry into the MSB and fa_c the carry out.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_r <= 1'b0;
        end else if (clear) begin
            ovf_r <= 1'b0;
        end else if (state == SHIFT && last_bit) begin
            ovf_r <= carry ^ fa_c;
        end
    end

    assign ovf = ovf_r;
`endif

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Self-checking bench for serial_adder_ctrl at WIDTH=8: directed vector table,
// handshake/clear/reset corner sequences and a back-to-back random run.
module tb_serial_adder_ctrl;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         clear;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         c_in;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         c_out;
`ifdef SERIAL_ADDER_CTRL_OVF_EN
    logic         ovf;
`endif

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    serial_adder_ctrl #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .clear     (clear),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .c_in      (c_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .c_out     (c_out)
`ifdef SERIAL_ADDER_CTRL_OVF_EN
        ,
        .ovf       (ovf)
`endif
    );

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        logic [7:0] s;
        logic       co;
        logic       ov;
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Drive one operand set (called #1 after an edge), then count edges until
    // out_valid; inputs are scrambled after the accept edge.
    task automatic do_op(input logic [7:0] ai, input logic [7:0] bi, input logic ci,
                         output int lat);
        a        = ai;
        b        = bi;
        c_in     = ci;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a        = 8'($urandom);
        b        = 8'($urandom);
        c_in     = 1'($urandom);
        lat      = 0;
        while (!out_valid && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic count_valid(input int cycles, output int seen);
        seen = 0;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk);
            #1;
            if (out_valid) seen++;
        end
    endtask

    initial begin
        int         lat;
        int         seen;
        logic [7:0] ra;
        logic [7:0] rb;
        logic       rc;
        logic [8:0] full;

        vecs[0] = '{8'h05, 8'h03, 1'b0, 8'h08, 1'b0, 1'b0};
        vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
        vecs[2] = '{8'h10, 8'h20, 1'b0, 8'h30, 1'b0, 1'b0};
        vecs[3] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};
        vecs[4] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1};
        vecs[5] = '{8'h00, 8'h00, 1'b1, 8'h01, 1'b0, 1'b0};
        vecs[6] = '{8'hAA, 8'h55, 1'b0, 8'hFF, 1'b0, 1'b0};
        vecs[7] = '{8'hAA, 8'h55, 1'b1, 8'h00, 1'b1, 1'b0};
        vecs[8] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};

        rst       = 1'b1;
        clear     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        c_in      = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready",  32'(in_ready),  32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_sum",       32'(sum),       32'd0);
        check("rst_c_out",     32'(c_out),     32'd0);
`ifdef SERIAL_ADDER_CTRL_OVF_EN
        check("rst_ovf",       32'(ovf),       32'd0);
`endif
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Directed table, one result pulled per operation.
        for (int i = 0; i < 9; i++) begin
            check($sformatf("vec%0d_in_ready", i), 32'(in_ready), 32'd1);
            do_op(vecs[i].a, vecs[i].b, vecs[i].cin, lat);
            check($sformatf("vec%0d_latency", i), 32'(lat),   32'd8);
            check($sformatf("vec%0d_sum", i),     32'(sum),   32'(vecs[i].s));
            check($sformatf("vec%0d_c_out", i),   32'(c_out), 32'(vecs[i].co));
`ifdef SERIAL_ADDER_CTRL_OVF_EN
            check($sformatf("vec%0d_ovf", i),     32'(ovf),   32'(vecs[i].ov));
`endif
            out_ready = 1'b1;
            @(posedge clk);
            #1;
            out_ready = 1'b0;
            check($sformatf("vec%0d_back_idle", i), 32'(in_ready), 32'd1);
        end

        // Hold the result for five cycles, then release with in_valid already high.
        do_op(8'h12, 8'h34, 1'b0, lat);
        check("hold_latency", 32'(lat), 32'd8);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check($sformatf("hold%0d_sum", i),       32'(sum),       32'h46);
            check($sformatf("hold%0d_c_out", i),     32'(c_out),     32'd0);
            check($sformatf("hold%0d_in_ready", i),  32'(in_ready),  32'd0);
            check($sformatf("hold%0d_out_valid", i), 32'(out_valid), 32'd1);
        end
        a         = 8'h01;
        b         = 8'h01;
        c_in      = 1'b0;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("release_no_accept", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("release_accept_next", 32'(in_ready), 32'd0);
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("release_latency", 32'(lat), 32'd8);
        check("release_sum",     32'(sum), 32'h02);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;

        // clear during the fourth SHIFT cycle.
        a        = 8'hFF;
        b        = 8'h01;
        c_in     = 1'b0;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        clear = 1'b1;
        @(posedge clk);
        #1;
        clear = 1'b0;
        check("clear_in_ready",  32'(in_ready),  32'd1);
        check("clear_out_valid", 32'(out_valid), 32'd0);
        count_valid(12, seen);
        check("clear_no_result", 32'(seen), 32'd0);
        do_op(8'h10, 8'h20, 1'b0, lat);
        check("after_clear_latency", 32'(lat),   32'd8);
        check("after_clear_sum",     32'(sum),   32'h30);
        check("after_clear_c_out",   32'(c_out), 32'd0);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;

        // Asynchronous reset between edges in the middle of SHIFT.
        a        = 8'hFF;
        b        = 8'hFF;
        c_in     = 1'b1;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("arst_in_ready",  32'(in_ready),  32'd1);
        check("arst_out_valid", 32'(out_valid), 32'd0);
        check("arst_sum",       32'(sum),       32'd0);
        check("arst_c_out",     32'(c_out),     32'd0);
        @(negedge clk);
        rst = 1'b0;
        count_valid(15, seen);
        check("arst_no_result", 32'(seen),     32'd0);
        check("arst_idle",      32'(in_ready), 32'd1);

        // Back-to-back random operations with the consumer always ready.
        out_ready = 1'b1;
        for (int i = 0; i < 100; i++) begin
            ra   = 8'($urandom);
            rb   = 8'($urandom);
            rc   = 1'($urandom);
            full = {1'b0, ra} + {1'b0, rb} + {8'b0, rc};
            do_op(ra, rb, rc, lat);
            check($sformatf("rnd%0d_latency", i), 32'(lat),   32'd8);
            check($sformatf("rnd%0d_sum", i),     32'(sum),   32'(full[7:0]));
            check($sformatf("rnd%0d_c_out", i),   32'(c_out), 32'(full[8]));
            @(posedge clk);
            #1;
        end
        out_ready = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
